// File: rtl/onewire_pkg.sv
// Shared 1-Wire slave definitions: FSM states, command codes and the fixed
// scratchpad contents.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE, RST_LOW, PRES_WAIT, PRES_DRV, ROM_CMD, FUNC_CMD, TX_SCR, CONV
    } state_e;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_READ_SCR = 8'hBE;
    localparam logic [7:0] CMD_CONV_T   = 8'h44;

    localparam logic [7:0] SCR_TH   = 8'h4B;
    localparam logic [7:0] SCR_TL   = 8'h46;
    localparam logic [7:0] SCR_CFG  = 8'h7F;
    localparam logic [7:0] SCR_RES0 = 8'hFF;
    localparam logic [7:0] SCR_RES1 = 8'h0C;
    localparam logic [7:0] SCR_RES2 = 8'h10;

    localparam logic [15:0] T_RESET = 16'h0550;

    localparam int unsigned PRES_WAIT_US = 30;
    localparam int unsigned PRES_DRV_US  = 120;

    // Scratchpad byte 0..8; index 8 and above is the CRC.
    function automatic logic [7:0] scr_byte(input logic [3:0] idx,
                                            input logic [15:0] t,
                                            input logic [7:0] crc);
        case (idx)
            4'd0:    return t[7:0];
            4'd1:    return t[15:8];
            4'd2:    return SCR_TH;
            4'd3:    return SCR_TL;
            4'd4:    return SCR_CFG;
            4'd5:    return SCR_RES0;
            4'd6:    return SCR_RES1;
            4'd7:    return SCR_RES2;
            default: return crc;
        endcase
    endfunction

endpackage

// File: rtl/onewire_slave_if.sv
// Sideband bundle around the 1-Wire slave: master bus pull, temperature
// source and the slave's status outputs.
interface onewire_slave_if;
    logic        mst_low;
    logic [15:0] temp;
    logic        conv_busy;
    logic        cmd_err;

    modport master (output mst_low, temp, input conv_busy, cmd_err);
    modport slave  (input mst_low, temp, output conv_busy, cmd_err);
endinterface

// File: rtl/onewire_crc8.sv
// Bit-serial Dallas CRC-8 (x^8+x^5+x^4+1, reflected, init 0).
module onewire_crc8 (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);
    logic [7:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[0] ^ bit_i;
        crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)      crc_q <= '0;
        else if (clr_i)  crc_q <= '0;
        else if (en_i)   crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/onewire_slave.sv
// DS18B20-style 1-Wire slave: reset/presence, Skip ROM, Read Scratchpad and
// Convert T, driving the open-drain bus only low.
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int unsigned CLK_MHZ    = 50,
    parameter int unsigned RST_MIN_US = 400,
    parameter int unsigned SAMPLE_US  = 30,
    parameter int unsigned HOLD_US    = 30,
    parameter int unsigned CONV_US    = 750000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    inout  wire         dq,
    input  logic [15:0] temp_in,
    output logic        conv_busy,
    output logic        cmd_err
);
    localparam int unsigned RST_CYC    = CLK_MHZ * RST_MIN_US;
    localparam int unsigned SAMPLE_CYC = CLK_MHZ * SAMPLE_US;
    localparam int unsigned HOLD_CYC   = CLK_MHZ * HOLD_US;
    localparam int unsigned PW_CYC     = CLK_MHZ * PRES_WAIT_US;
    localparam int unsigned PD_CYC     = CLK_MHZ * PRES_DRV_US;
    localparam int unsigned CONV_CYC   = CLK_MHZ * CONV_US;
    localparam int unsigned SH_MAX     = (SAMPLE_CYC > HOLD_CYC) ? SAMPLE_CYC : HOLD_CYC;
    localparam int unsigned TMR_MAX    = (PD_CYC > SH_MAX) ? PD_CYC : SH_MAX;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
    localparam int unsigned LOW_W      = $clog2(RST_CYC + 1);
    localparam int unsigned CONV_W     = $clog2(CONV_CYC + 1);

    logic [1:0]        rsync_q;
    logic [2:0]        dq_sync_q;
    logic [LOW_W-1:0]  low_cnt_q, low_cnt_d;
    state_e            state_q;
    logic              drv_q, conv_busy_q, cmd_err_q, armed_q, in_slot_q;
    logic [15:0]       t_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [CONV_W-1:0] conv_cnt_q;
    logic [6:0]        bit_idx_q, sr_q;
    logic              crc_clr_q, crc_en_q, crc_bit_q;
    logic [7:0]        crc, tx_byte, rx_byte;
    logic              run, dq_s, fall, rise, bus_rst, tx_bit;

    // Deassertion is released through two flops; logic idles until then.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) rsync_q <= '0;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end
    assign run = rsync_q[1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dq_sync_q <= 3'b111;
            low_cnt_q <= '0;
        end else begin
            dq_sync_q <= {dq_sync_q[1:0], dq};
            low_cnt_q <= low_cnt_d;
        end
    end

    assign dq_s      = dq_sync_q[1];
    assign fall      = dq_sync_q[2] & ~dq_s;
    assign rise      = ~dq_sync_q[2] & dq_s;
    assign low_cnt_d = dq_s ? '0 :
                       (low_cnt_q == LOW_W'(RST_CYC)) ? low_cnt_q : low_cnt_q + 1'b1;
    assign bus_rst   = !dq_s && (low_cnt_q == LOW_W'(RST_CYC));
    assign tx_byte   = scr_byte(bit_idx_q[6:3], t_q, crc);
    assign tx_bit    = tx_byte[bit_idx_q[2:0]];
    assign rx_byte   = {dq_s, sr_q};

    onewire_crc8 u_crc (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr_i  (crc_clr_q),
        .en_i   (crc_en_q),
        .bit_i  (crc_bit_q),
        .crc_o  (crc)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drv_q       <= 1'b0;
            conv_busy_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            armed_q     <= 1'b0;
            in_slot_q   <= 1'b0;
            t_q         <= T_RESET;
            tmr_q       <= '0;
            conv_cnt_q  <= '0;
            bit_idx_q   <= '0;
            sr_q        <= '0;
            crc_clr_q   <= 1'b0;
            crc_en_q    <= 1'b0;
            crc_bit_q   <= 1'b0;
        end else if (run) begin
            cmd_err_q <= 1'b0;
            crc_clr_q <= 1'b0;
            crc_en_q  <= 1'b0;
            // Conversion runs off its own counter so a bus reset can't abort it.
            if (conv_busy_q) begin
                if (conv_cnt_q == CONV_W'(CONV_CYC - 1)) begin
                    conv_busy_q <= 1'b0;
                    t_q         <= temp_in;
                end else begin
                    conv_cnt_q <= conv_cnt_q + 1'b1;
                end
            end
            if (bus_rst) begin
                state_q   <= RST_LOW;
                drv_q     <= 1'b0;
                armed_q   <= 1'b0;
                in_slot_q <= 1'b0;
                tmr_q     <= '0;
                bit_idx_q <= '0;
            end else begin
                case (state_q)
                    RST_LOW: if (rise) begin
                        state_q <= PRES_WAIT;
                        tmr_q   <= '0;
                    end
                    PRES_WAIT: if (tmr_q == TMR_W'(PW_CYC - 1)) begin
                        state_q <= PRES_DRV;
                        drv_q   <= 1'b1;
                        tmr_q   <= '0;
                    end else tmr_q <= tmr_q + 1'b1;
                    PRES_DRV: if (tmr_q == TMR_W'(PD_CYC - 1)) begin
                        state_q   <= ROM_CMD;
                        drv_q     <= 1'b0;
                        tmr_q     <= '0;
                        armed_q   <= 1'b0;
                        bit_idx_q <= '0;
                    end else tmr_q <= tmr_q + 1'b1;
                    ROM_CMD, FUNC_CMD: begin
                        if (in_slot_q) begin
                            if (tmr_q == TMR_W'(SAMPLE_CYC - 1)) begin
                                in_slot_q <= 1'b0;
                                sr_q      <= rx_byte[7:1];
                                bit_idx_q <= bit_idx_q + 7'd1;
                                if (bit_idx_q[2:0] == 3'd7) begin
                                    bit_idx_q <= '0;
                                    if (state_q == ROM_CMD && rx_byte == CMD_SKIP_ROM) begin
                                        state_q <= FUNC_CMD;
                                    end else if (state_q == FUNC_CMD && rx_byte == CMD_READ_SCR) begin
                                        state_q   <= TX_SCR;
                                        crc_clr_q <= 1'b1;
                                    end else if (state_q == FUNC_CMD && rx_byte == CMD_CONV_T) begin
                                        state_q     <= CONV;
                                        conv_busy_q <= 1'b1;
                                        conv_cnt_q  <= '0;
                                    end else begin
                                        state_q   <= IDLE;
                                        cmd_err_q <= 1'b1;
                                    end
                                end
                            end else tmr_q <= tmr_q + 1'b1;
                        end else if (!armed_q) armed_q <= dq_s;
                        else if (fall) begin
                            in_slot_q <= 1'b1;
                            armed_q   <= 1'b0;
                            tmr_q     <= '0;
                        end
                    end
                    TX_SCR, CONV: begin
                        if (in_slot_q) begin
                            if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
                                in_slot_q <= 1'b0;
                                drv_q     <= 1'b0;
                                if (state_q == TX_SCR) begin
                                    bit_idx_q <= bit_idx_q + 7'd1;
                                    if (bit_idx_q == 7'd71) state_q <= IDLE;
                                end
                            end else tmr_q <= tmr_q + 1'b1;
                        end else if (!armed_q) armed_q <= dq_s;
                        else if (fall) begin
                            in_slot_q <= 1'b1;
                            armed_q   <= 1'b0;
                            tmr_q     <= '0;
                            if (state_q == TX_SCR) begin
                                drv_q     <= !tx_bit;
                                crc_en_q  <= !bit_idx_q[6];
                                crc_bit_q <= tx_bit;
                            end else begin
                                drv_q <= conv_busy_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dq        = drv_q ? 1'b0 : 1'bz;
    assign conv_busy = conv_busy_q;
    assign cmd_err   = cmd_err_q;
endmodule

// File: doc/onewire_slave.md
ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50, clk_in frequency in MHz; all microsecond timings are CLK_MHZ*us cycles.
REQ-002 SHALL have parameter RST_MIN_US, default 400, minimum dq low time recognised as a bus reset.
REQ-003 SHALL have parameter SAMPLE_US, default 30, delay from slot falling edge to the write-bit sample.
REQ-004 SHALL have parameter HOLD_US, default 30, time dq is held low from the slot falling edge when transmitting a 0.
REQ-005 SHALL have parameter CONV_US, default 750000, Convert T duration.
REQ-006 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port dq  inout  1  1-Wire bus; driven only to 0 or Z, never to 1.
REQ-009 SHALL have port temp_in  input  16  DS18B20-format two's-complement temperature, sampled at conversion end.
REQ-010 SHALL have port conv_busy  output  1  high while a Convert T is in progress.
REQ-011 SHALL have port cmd_err  output  1  one-cycle pulse on an unsupported ROM or function command.

Function
REQ-012 SHALL pass dq through a 2-flop synchroniser; all edge detection and counting SHALL use the synchronised value.
REQ-013 SHALL count continuous low time; reaching RST_MIN_US SHALL force state RST_LOW from any state, aborting any transfer.
REQ-014 SHALL implement states IDLE, RST_LOW, PRES_WAIT, PRES_DRV, ROM_CMD, FUNC_CMD, TX_SCR, CONV.
REQ-015 RST_LOW -> PRES_WAIT on dq rise; PRES_WAIT lasts 30 us; PRES_DRV drives dq low for 120 us, then enters ROM_CMD.
REQ-016 ROM_CMD/FUNC_CMD SHALL receive 8 bits LSB-first; each bit is the synchronised dq sampled SAMPLE_US after a falling edge.
REQ-017 After each slot the block SHALL wait for dq high before arming on the next falling edge.
REQ-018 ROM byte 0xCC -> FUNC_CMD; any other ROM byte SHALL pulse cmd_err and enter IDLE (no bus drive until next reset).
REQ-019 Function 0xBE -> TX_SCR; 0x44 -> CONV; any other SHALL pulse cmd_err and enter IDLE.
REQ-020 TX_SCR SHALL send 9 bytes LSB-first: T[7:0], T[15:8], 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC.
REQ-021 CRC SHALL be Dallas CRC-8 (x^8+x^5+x^4+1, reflected, init 0x00) over bytes 0-7.
REQ-022 For each TX bit, on the slot falling edge the block SHALL drive dq low for HOLD_US if the bit is 0, otherwise leave dq released.
REQ-023 After the 72nd bit the block SHALL enter IDLE; further read slots SHALL see 1.
REQ-024 CONV SHALL assert conv_busy for CONV_US; read slots during CONV SHALL return 0.
REQ-025 At CONV end T SHALL load temp_in and conv_busy SHALL drop in the same cycle; read slots then SHALL return 1.
REQ-026 A bus reset during CONV SHALL NOT abort the conversion; conv_busy and the T update SHALL proceed independently.
REQ-027 A falling edge coincident with the presence end SHALL be ignored; the slot counter arms only after dq is seen high in ROM_CMD.

Reset
REQ-028 On rst_n low: state IDLE, dq released (Z), conv_busy 0, cmd_err 0, T = 0x0550, all counters and bit indices 0.
REQ-029 Deassertion SHALL be synchronised to clk_in; the block SHALL respond only after the next bus reset.

Structure
REQ-030 The command codes (0xCC, 0xBE, 0x44), scratchpad constant bytes, and state encoding SHALL live in shared package onewire_pkg.
REQ-031 The CRC SHALL be a sub-module onewire_crc8: bit-serial, with clear, enable and data-bit inputs and an 8-bit output.

Verification
REQ-032 Master holds dq low 480 us, then releases -> dq low from 30 us to 150 us after release, then released.
REQ-033 Reset, write 0xCC, 0xBE, 72 read slots with no prior conversion -> bytes 50 05 4B 46 7F FF 0C 10 1C.
REQ-034 Reset, 0xCC, 0x44 with CONV_US=100 and temp_in=0x0191; read slots during CONV -> 0; after 100 us -> 1; then reset, 0xCC, 0xBE -> first bytes 91 01, CRC matching model.
REQ-035 Reset, write ROM byte 0x33 -> cmd_err pulse; 16 read slots -> all 1, dq never driven.
REQ-036 480 us reset issued after byte 3 of TX_SCR -> transfer aborted, presence pulse per REQ-032, next 0xCC 0xBE restarts at byte 0.
REQ-037 rst_n asserted while dq held low mid-HOLD_US -> dq released within the same cycle, all outputs at reset values.
